// File: rtl/reduce_seq_unit_pkg.sv
// Shared types and helpers for the sequential bitwise-reduction unit.
// Holds the op/state encodings, default geometry and acc seed value.
package reduce_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 8;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_EQ  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Identity element of each fold: AND-like modes start at 1, OR/XOR at 0.
    function automatic logic acc_init(input op_e op);
        return (op == OP_AND) || (op == OP_EQ);
    endfunction

endpackage

// File: rtl/reduce_seq_unit_if.sv
// Request/response bundle between a requester (master) and the reduction unit (slave).
// Both directions use a valid/ready handshake.
interface reduce_seq_unit_if
    import reduce_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    op_e              op;
    logic             out_valid;
    logic             out_ready;
    logic             y;
    logic             early;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y, early
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y, early
    );

endinterface

// File: rtl/reduce_seq_unit_chunk.sv
// Combinational per-chunk reduction: collapses one CHUNK-bit slice of a/b to a bit.
// Zero latency, no flow control.
module reduce_chunk
    import reduce_pkg::*;
#(
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] a_c_i,
    input  logic [CHUNK-1:0] b_c_i,
    input  op_e              op_i,
    output logic             val_o
);

    always_comb begin
        val_o = 1'b0;
        case (op_i)
            OP_AND:  val_o = &(a_c_i & b_c_i);
            OP_OR:   val_o = |(a_c_i & b_c_i);
            OP_XOR:  val_o = ^(a_c_i ^ b_c_i);
            OP_EQ:   val_o = &(~(a_c_i ^ b_c_i));
            default: val_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/reduce_seq_unit.sv
// Multi-cycle reduction of two WIDTH-bit operands, CHUNK bits per cycle, LSB chunk first.
// Latency N+1 cycles to out_valid (k+2 on early exit at chunk k); DONE holds under out_ready=0.
module reduce_seq_unit
    import reduce_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic               clk,
    input  logic               rst_n,
    reduce_seq_unit_if.slave   bus
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_geometry
            $fatal(1, "reduce_seq_unit: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    op_e                op_q, op_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               acc_q, acc_d;
    logic               y_q, y_d;
    logic               early_q, early_d;

    logic               chunk_val;
    logic               acc_fold;
    logic               stop_hit;
    logic               last_chunk;

    // Operands are shifted down each cycle, so the current chunk is always the low slice.
    reduce_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_c_i (a_q[CHUNK-1:0]),
        .b_c_i (b_q[CHUNK-1:0]),
        .op_i  (op_q),
        .val_o (chunk_val)
    );

    always_comb begin
        acc_fold = acc_q & chunk_val;
        stop_hit = 1'b0;
        case (op_q)
            OP_OR: begin
                acc_fold = acc_q | chunk_val;
                stop_hit = acc_fold;
            end
            OP_XOR: begin
                acc_fold = acc_q ^ chunk_val;
                stop_hit = 1'b0;
            end
            default: begin
                acc_fold = acc_q & chunk_val;
                stop_hit = ~acc_fold;
            end
        endcase
        last_chunk = (idx_q == IDX_W'(N - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        y_d     = y_q;
        early_d = early_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = bus.op;
                    idx_d   = '0;
                    acc_d   = acc_init(bus.op);
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> CHUNK;
                b_d   = b_q >> CHUNK;
                acc_d = acc_fold;
                idx_d = idx_q + 1'b1;
                if (last_chunk || stop_hit) begin
                    y_d     = acc_fold;
                    early_d = stop_hit && !last_chunk;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_AND;
            idx_q   <= '0;
            acc_q   <= 1'b0;
            y_q     <= 1'b0;
            early_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            early_q <= early_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.y         = y_q;
    assign bus.early     = early_q;

endmodule

// File: tb/tb_reduce_seq_unit.sv
// Bench for reduce_seq_unit: directed cases with literal expectations plus randomized traffic
// compared every cycle against a transaction-level model of result, early flag and latency.
module tb_reduce_seq_unit;
    import reduce_pkg::*;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int N     = WIDTH / CHUNK;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    reduce_seq_unit_if #(.WIDTH(WIDTH)) bus ();

    reduce_seq_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Result from whole-operand reduction; exit chunk = first chunk whose value dominates.
    function automatic void predict(input op_e o, input logic [31:0] aa, input logic [31:0] bb,
                                    output logic py, output logic pe, output int px);
        logic [7:0] ca, cb;
        bit found;
        found = 0;
        px = N - 1;
        case (o)
            OP_AND: py = &(aa & bb);
            OP_OR:  py = |(aa & bb);
            OP_XOR: py = ^(aa ^ bb);
            default: py = (aa == bb);
        endcase
        for (int k = 0; k < N; k++) begin
            ca = aa[k*CHUNK +: CHUNK];
            cb = bb[k*CHUNK +: CHUNK];
            if (!found) begin
                if ((o == OP_AND && (ca & cb) != 8'hFF) ||
                    (o == OP_EQ  && ca != cb) ||
                    (o == OP_OR  && (ca & cb) != 8'h00)) begin
                    found = 1;
                    px = k;
                end
            end
        end
        pe = found && (px < N - 1);
    endfunction

    // Transaction-level model: 0 idle, 1 busy, 2 result presented.
    int   m_phase = 0;
    int   m_cd = 0;
    logic m_valid = 1'b0;
    logic m_y = 1'b0;
    logic m_early = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic py, pe;
        int   px;
        if (!rst_n) begin
            m_phase = 0;
            m_valid = 1'b0;
            m_y     = 1'b0;
            m_early = 1'b0;
        end else begin
            case (m_phase)
                0: if (bus.in_valid) begin
                    predict(bus.op, bus.a, bus.b, py, pe, px);
                    m_cd    = px + 1;
                    m_phase = 1;
                    m_y     = py;
                    m_early = pe;
                end
                1: begin
                    m_cd--;
                    if (m_cd == 0) begin
                        m_phase = 2;
                        m_valid = 1'b1;
                    end
                end
                default: if (bus.out_ready) begin
                    m_phase = 0;
                    m_valid = 1'b0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, m_phase == 0});
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("y", {31'd0, bus.y}, {31'd0, m_y});
            chk("early", {31'd0, bus.early}, {31'd0, m_early});
        end
    end

    // Starts at posedge+1 in IDLE; returns at posedge+1 of the cycle after the handshake.
    task automatic issue(input op_e o, input logic [31:0] aa, input logic [31:0] bb,
                         input int hold, input bit lit, input logic ey, input logic ee,
                         input int ecyc, input bit noise);
        int cyc;
        bit got;
        bus.in_valid = 1'b1;
        bus.op = o;
        bus.a  = aa;
        bus.b  = bb;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a  = $urandom;
        bus.b  = $urandom;
        bus.op = op_e'($urandom_range(0, 3));
        cyc = 1;
        got = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            if (bus.out_valid) got = 1;
            else begin
                @(posedge clk); #1;
                if (noise) bus.in_valid = 1'($urandom_range(0, 1));
                cyc++;
            end
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: out_valid not seen within %0d cycles", cyc);
        end else if (lit) begin
            chk("lit_y", {31'd0, bus.y}, {31'd0, ey});
            chk("lit_early", {31'd0, bus.early}, {31'd0, ee});
            chk("lit_cycle", cyc, ecyc);
        end
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, rb, one;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = OP_AND;
        bus.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_y", {31'd0, bus.y}, 32'd0);
        chk("rst_early", {31'd0, bus.early}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(OP_AND, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 1'b1, 1'b0, 5, 0);
        issue(OP_AND, 32'hFFFFFF00, 32'hFFFFFFFF, 0, 1, 1'b0, 1'b1, 2, 0);
        issue(OP_OR,  32'h00010000, 32'h00010000, 0, 1, 1'b1, 1'b1, 4, 0);
        issue(OP_XOR, 32'h00000007, 32'h00000000, 0, 1, 1'b1, 1'b0, 5, 0);
        issue(OP_XOR, 32'h12345678, 32'h12345678, 0, 1, 1'b0, 1'b0, 5, 0);
        issue(OP_EQ,  32'hDEADBEEF, 32'hDEADBEEF, 3, 1, 1'b1, 1'b0, 5, 0);
        @(negedge clk);
        chk("post_hs_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;

        // Abort an in-flight AND with a reset pulse in cycle 2.
        bus.in_valid = 1'b1;
        bus.op = OP_AND;
        bus.a  = 32'hFFFFFFFF;
        bus.b  = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        issue(OP_EQ, 32'h00000001, 32'h00000000, 0, 1, 1'b0, 1'b1, 2, 0);

        for (int t = 0; t < 150; t++) begin
            ra  = $urandom;
            one = 32'd1 << $urandom_range(0, 31);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ one;
                2: rb = $urandom;
                default: begin
                    ra = 32'hFFFFFFFF;
                    rb = 32'hFFFFFFFF & ~(($urandom_range(0, 1) != 0) ? one : 32'd0);
                end
            endcase
            issue(op_e'($urandom_range(0, 3)), ra, rb, $urandom_range(0, 3), 0, 1'b0, 1'b0, 0, 1);
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reduce_seq_unit.md
# reduce_seq_unit

Parametrised, multi-cycle bitwise-reduction unit for the ALU datapath. It is the general successor of the fixed-width AND-tree reducers. It reduces two WIDTH-bit operands to a single result bit, CHUNK bits per cycle, and supports four reduction modes. Operands are accepted and results returned over valid/ready handshakes, and modes with a dominating value terminate early.

## Interface
Parameters:
- WIDTH, 32, operand width in bits.
- CHUNK, 8, bits reduced per cycle. WIDTH % CHUNK must be 0 and CHUNK ≥ 1. N = WIDTH/CHUNK.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand/op request.
- in_ready  output  1  unit idle and able to accept a request.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  2  mode: 00 AND = &(a&b), 01 OR = |(a&b), 10 XOR = ^(a^b), 11 EQ = (a==b).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- y  output  1  reduction result.
- early  output  1  result produced before all N chunks were processed.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid, capture a, b and op, clear the chunk index, initialise acc, and go to RUN.
  - RUN: each cycle, reduce chunk[idx] = bits [idx*CHUNK +: CHUNK], starting at the LSB chunk, and fold the result into acc. Go to DONE after chunk N-1 or on an early-exit condition.
  - DONE: out_valid=1 with y=acc. On out_ready, go to IDLE.
- acc initial value: 1 for AND and EQ; 0 for OR and XOR.
- Per-chunk value and fold:
  - AND: &(a_c&b_c), folded with acc&=.
  - OR: |(a_c&b_c), folded with acc|=.
  - XOR: ^(a_c^b_c), folded with acc^=.
  - EQ: &~(a_c^b_c), folded with acc&=.
- Early exit: the condition is evaluated on the newly folded acc.
  - AND and EQ exit when acc becomes 0.
  - OR exits when acc becomes 1.
  - XOR never exits early.
  - early=1 iff the exit occurred on a chunk with idx < N-1.
- in_ready is decoded from state: high only in IDLE. in_valid is ignored outside IDLE.
- y and early are held stable for as long as out_valid is high. They are not modified until the next result.
- a, b and op are sampled only at acceptance. Later changes on these inputs have no effect on the operation in flight.
- Reset:
  - Asserting rst_n in any state forces IDLE and aborts any in-flight operation; no result is emitted.
  - Reset values: out_valid=0, y=0, early=0, acc=0, idx=0.
  - in_ready reads 1 while in reset, but requests are not accepted while rst_n=0.

## Timing
- Cycle 0 is the acceptance cycle (in_valid & in_ready at the rising edge).
- Chunk j is processed in cycle j+1.
- Full-length result: out_valid is first high in cycle N+1.
- Early exit on chunk k: out_valid is first high in cycle k+2.
- Degenerate case CHUNK=WIDTH (N=1): out_valid in cycle 2, and early is always 0.
- DONE is held indefinitely under backpressure (out_ready=0).
- A new request can be accepted no earlier than the cycle after the out_valid & out_ready handshake. There is no overlap between operations.
- Maximum throughput: one operation per N+2 cycles.

## Structure
- Shared package reduce_pkg holds:
  - op_e enum (OP_AND, OP_OR, OP_XOR, OP_EQ);
  - state_e enum (IDLE, RUN, DONE);
  - default WIDTH and CHUNK constants;
  - acc-initial-value function.
- Sub-module reduce_chunk (combinational, parameter CHUNK): inputs a_c, b_c and op; output is the 1-bit chunk value. The top level contains the FSM, the captured operand registers, idx, and acc.
- Parameter legality (WIDTH % CHUNK == 0) is checked at elaboration and is a fatal error if violated.

## Test plan
All tests use WIDTH=32, CHUNK=8 (N=4).
- AND, a=b=32'hFFFFFFFF → y=1, early=0, out_valid first high in cycle 5.
- AND, a=32'hFFFFFF00, b=32'hFFFFFFFF → y=0, early=1, out_valid first high in cycle 2.
- OR, a=b=32'h00010000 → y=1, early=1, out_valid first high in cycle 4 (exit on chunk 2).
- XOR, a=32'h00000007, b=0 → y=1, early=0, out_valid in cycle 5. Also XOR, a=b=32'h12345678 → y=0.
- EQ, a=b=32'hDEADBEEF, with out_ready held low for 3 cycles → y=1 held stable and in_ready=0 throughout. Handshake in cycle 8 → in_ready=1 in cycle 9.
- AND with all-ones operands, rst_n pulsed low in cycle 2 → out_valid never asserts. After release, a new EQ request with a=1, b=0 → y=0, early=1, out_valid in cycle 2.
